sysex_patch_dump: RTL and testbench
===================================

SYSEX_PATCH_DUMP -- requirements
Module: sysex_patch_dump

Interface
REQ-001 SHALL have parameter V_OSC, default 4: oscillators per voice; sets the osc/matrix bank sizes.
REQ-002 SHALL have parameter MFR_ID, default 8'h7D: SysEx manufacturer byte.
REQ-003 SHALL have parameter DEV_ID, default 8'h00: SysEx device byte.
REQ-004 sCLK_XVXENVS  in  1  clock; all logic on its rising edge.
REQ-005 reset_reg_N  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  one-cycle dump request.
REQ-007 busy  out  1  high from accepted start until return to IDLE.
REQ-008 done  out  1  one-cycle pulse on dump completion.
REQ-009 adr  out  7  parameter bus address.
REQ-010 osc_sel, com_sel, m1_sel, m2_sel  out  1 each  bank selects; at most one high at a time.
REQ-011 read  out  1  read strobe; the responder latches its data_out on the rising edge of read.
REQ-012 sysex_data_patch_send  out  1  enables the responders' bus drivers.
REQ-013 data  in  8  parameter bus read data.
REQ-014 tx_data  out  8  byte to the MIDI transmitter.
REQ-015 tx_valid  out  1  tx_data valid.
REQ-016 tx_ready  in  1  transmitter accepts the byte.

Function
REQ-017 SHALL implement FSM states IDLE, HDR, SETUP, STROBE, CAPTURE, SEND, NEXT, TRL, FIN.
REQ-018 start in IDLE SHALL move to HDR if SYSEX_FRAME_EN is defined, else to SETUP; start in any other state SHALL be ignored.
REQ-019 Bank order: osc, com, m1, m2.
REQ-020 osc bank: for osc n = 0..V_OSC-1, offsets 2, 3, 4, 7, 10, 11, 12, 13, 14, 15 in that order; adr = (n<<4) + offset.
REQ-021 com bank: adr 1..15; m1 bank and m2 bank: adr 0..(V_OSC*16-1) each.
REQ-022 Total parameter bytes: 10*V_OSC + 15 + 32*V_OSC (183 at default).
REQ-023 SETUP SHALL last 1 cycle: drive adr and the bank select, read low.
REQ-024 STROBE SHALL last 1 cycle with read high.
REQ-025 CAPTURE SHALL last 1 cycle with read high; data is sampled at the end of CAPTURE, and read drops on leaving CAPTURE.
REQ-026 adr and the selects SHALL be held stable from SETUP through CAPTURE.
REQ-027 SEND SHALL present tx_data = {1'b0, captured[6:0]} with tx_valid high.
REQ-028 A transfer occurs on a rising edge where tx_valid and tx_ready are both high.
REQ-029 tx_data SHALL be held stable while tx_valid is high and tx_ready is low.
REQ-030 tx_valid SHALL drop in the cycle after the transfer.
REQ-031 NEXT SHALL advance the address, or move to the next bank when the current one wraps.
REQ-032 After the last m2 address, NEXT SHALL go to TRL if SYSEX_FRAME_EN is defined, else to FIN.
REQ-033 FIN SHALL pulse done for 1 cycle, deassert busy, and return to IDLE.
REQ-034 sysex_data_patch_send SHALL be high in every state except IDLE and FIN.
REQ-035 Minimum per-parameter cost SHALL be 5 cycles (SETUP, STROBE, CAPTURE, SEND with tx_ready=1, NEXT).
REQ-036 tx_ready held low SHALL stall in SEND indefinitely with no address or select change.

Reset
REQ-037 Asserting reset_reg_N low at any time, including mid-dump, SHALL force IDLE.
REQ-038 On reset, all outputs SHALL be 0: adr, all selects, read, sysex_data_patch_send, tx_valid, tx_data, busy, done.
REQ-039 On reset, the address and bank counters SHALL clear.
REQ-040 No partial frame SHALL resume after reset; a new start restarts from osc adr 2.

Configuration
REQ-041 Macro SYSEX_FRAME_EN SHALL control SysEx framing.
REQ-042 With SYSEX_FRAME_EN defined, HDR SHALL send F0, MFR_ID, DEV_ID (each via the SEND handshake) before the parameters, and TRL SHALL send F7 after them.
REQ-043 Without SYSEX_FRAME_EN, HDR and TRL SHALL be unreachable and only the raw parameter bytes are sent.

Structure
REQ-044 A shared package SHALL hold: the FSM state enum, the bank enum, the osc offset table {2,3,4,7,10..15}, SOX=8'hF0, EOX=8'hF7, and the osc/com bank sizes.
REQ-045 A sub-module patch_adr_seq SHALL generate bank, adr and last flags, with step/clear inputs.

Verification
REQ-046 After reset, start with a responder model at reset values and tx_ready=1 -> with framing, first bytes F0, 7D, 00, 40 (osc_lvl[0] at adr 2); 187 bytes total, ending in F7; one done pulse.
REQ-047 Without SYSEX_FRAME_EN -> exactly 183 bytes; first byte 40; done after the last m2 byte.
REQ-048 tx_ready low for 20 cycles during byte 5 -> tx_data and adr held constant; no byte lost or duplicated.
REQ-049 Responder returns 8'hC5 at m1 adr 0x21 -> that byte is transmitted as 8'h45.
REQ-050 reset_reg_N pulsed low at byte 50 -> all outputs 0 within the same cycle; a following start restarts with F0 (framed) or the adr-2 byte (raw).
REQ-051 start re-pulsed while busy -> ignored; byte count unchanged; exactly one done pulse.

Source files
------------

// File: rtl/sysex_patch_dump_pkg.sv
// rtl/sysex_patch_dump_pkg.sv - FSM/bank types, osc offset table and framing bytes for the patch dump
package sysex_patch_dump_pkg;

   typedef enum logic [3:0] {
      IDLE, HDR, SETUP, STROBE, CAPTURE, SEND, NEXT, TRL, FIN
   } state_t;

   typedef enum logic [1:0] {BANK_OSC, BANK_COM, BANK_M1, BANK_M2} bank_t;

   // What SEND returns to once the byte has been taken
   typedef enum logic [1:0] {PH_HDR, PH_PAR, PH_TRL} phase_t;

   localparam logic [7:0] SOX        = 8'hF0;
   localparam logic [7:0] EOX        = 8'hF7;
   localparam int         OSC_PARAMS = 10;
   localparam int         COM_SIZE   = 15;

   function automatic logic [3:0] osc_offset(input logic [3:0] idx);
      case (idx)
         4'd0:    osc_offset = 4'd2;
         4'd1:    osc_offset = 4'd3;
         4'd2:    osc_offset = 4'd4;
         4'd3:    osc_offset = 4'd7;
         4'd4:    osc_offset = 4'd10;
         4'd5:    osc_offset = 4'd11;
         4'd6:    osc_offset = 4'd12;
         4'd7:    osc_offset = 4'd13;
         4'd8:    osc_offset = 4'd14;
         default: osc_offset = 4'd15;
      endcase
   endfunction

endpackage

// File: rtl/sysex_patch_dump_adr_seq.sv
// rtl/sysex_patch_dump_adr_seq.sv - walks osc, com, m1, m2 parameter addresses in dump order
module patch_adr_seq
   import sysex_patch_dump_pkg::*;
#(
   parameter int V_OSC = 4
) (
   input  logic       sCLK_XVXENVS,
   input  logic       reset_reg_N,
   input  logic       clear,
   input  logic       step,
   output bank_t      bank,
   output logic [6:0] adr,
   output logic       last,
   output logic       last_all
);

   localparam logic [2:0] OSC_LAST = 3'(V_OSC - 1);
   localparam logic [6:0] MTX_LAST = 7'(V_OSC * 16 - 1);
   localparam logic [3:0] OFS_LAST = 4'(OSC_PARAMS - 1);
   localparam logic [6:0] COM_LAST = 7'(COM_SIZE - 1);

   bank_t      bank_q;
   logic [2:0] osc_n;
   logic [3:0] ofs_idx;
   logic [6:0] lin;

   always_ff @(posedge sCLK_XVXENVS or negedge reset_reg_N) begin
      if (!reset_reg_N) begin
         bank_q  <= BANK_OSC;
         osc_n   <= '0;
         ofs_idx <= '0;
         lin     <= '0;
      end else if (clear) begin
         bank_q  <= BANK_OSC;
         osc_n   <= '0;
         ofs_idx <= '0;
         lin     <= '0;
      end else if (step) begin
         if (last) begin
            // m2 wraps back to osc so the sequencer is ready for the next dump
            bank_q  <= bank_t'(bank_q + 2'd1);
            osc_n   <= '0;
            ofs_idx <= '0;
            lin     <= '0;
         end else if (bank_q == BANK_OSC) begin
            if (ofs_idx == OFS_LAST) begin
               ofs_idx <= '0;
               osc_n   <= osc_n + 3'd1;
            end else begin
               ofs_idx <= ofs_idx + 4'd1;
            end
         end else begin
            lin <= lin + 7'd1;
         end
      end
   end

   always_comb begin
      last = 1'b0;
      adr  = lin;
      case (bank_q)
         BANK_OSC: begin
            last = (osc_n == OSC_LAST) && (ofs_idx == OFS_LAST);
            adr  = {osc_n, osc_offset(ofs_idx)};
         end
         BANK_COM: begin
            last = (lin == COM_LAST);
            adr  = lin + 7'd1;
         end
         default: begin
            last = (lin == MTX_LAST);
            adr  = lin;
         end
      endcase
   end

   assign bank     = bank_q;
   assign last_all = last && (bank_q == BANK_M2);

endmodule

// File: rtl/sysex_patch_dump.sv
// rtl/sysex_patch_dump.sv - reads every patch parameter over the parameter bus and streams it to MIDI
// Define SYSEX_FRAME_EN to wrap the dump in F0 MFR_ID DEV_ID ... F7.
module sysex_patch_dump
   import sysex_patch_dump_pkg::*;
#(
   parameter int         V_OSC  = 4,
   parameter logic [7:0] MFR_ID = 8'h7D,
   parameter logic [7:0] DEV_ID = 8'h00
) (
   input  logic       sCLK_XVXENVS,
   input  logic       reset_reg_N,
   input  logic       start,
   output logic       busy,
   output logic       done,
   output logic [6:0] adr,
   output logic       osc_sel,
   output logic       com_sel,
   output logic       m1_sel,
   output logic       m2_sel,
   output logic       read,
   output logic       sysex_data_patch_send,
   input  logic [7:0] data,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready
);

   state_t     state, state_nxt;
   phase_t     phase, phase_nxt;
   logic [1:0] hdr_idx, hdr_idx_nxt;
   logic [7:0] tx_byte, tx_byte_nxt;
   logic       seq_clear, seq_step;
   bank_t      seq_bank;
   logic [6:0] seq_adr;
   logic       seq_last, seq_last_all;
   logic       bus_act;

   patch_adr_seq #(.V_OSC(V_OSC)) u_seq (
      .sCLK_XVXENVS (sCLK_XVXENVS),
      .reset_reg_N  (reset_reg_N),
      .clear        (seq_clear),
      .step         (seq_step),
      .bank         (seq_bank),
      .adr          (seq_adr),
      .last         (seq_last),
      .last_all     (seq_last_all)
   );

   always_ff @(posedge sCLK_XVXENVS or negedge reset_reg_N) begin
      if (!reset_reg_N) begin
         state   <= IDLE;
         phase   <= PH_PAR;
         hdr_idx <= '0;
         tx_byte <= '0;
      end else begin
         state   <= state_nxt;
         phase   <= phase_nxt;
         hdr_idx <= hdr_idx_nxt;
         tx_byte <= tx_byte_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      phase_nxt   = phase;
      hdr_idx_nxt = hdr_idx;
      tx_byte_nxt = tx_byte;
      seq_clear   = 1'b0;
      seq_step    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               seq_clear   = 1'b1;
               hdr_idx_nxt = 2'd0;
               phase_nxt   = PH_PAR;
`ifdef SYSEX_FRAME_EN
               state_nxt   = HDR;
`else
               state_nxt   = SETUP;
`endif
            end
         end
         HDR: begin
            phase_nxt = PH_HDR;
            case (hdr_idx)
               2'd0:    tx_byte_nxt = SOX;
               2'd1:    tx_byte_nxt = MFR_ID;
               default: tx_byte_nxt = DEV_ID;
            endcase
            state_nxt = SEND;
         end
         SETUP:   state_nxt = STROBE;
         STROBE:  state_nxt = CAPTURE;
         CAPTURE: begin
            // MIDI data bytes are 7-bit; bit 7 would read as a status byte
            tx_byte_nxt = data & 8'h7F;
            phase_nxt   = PH_PAR;
            state_nxt   = SEND;
         end
         SEND: begin
            if (tx_ready) begin
               case (phase)
                  PH_HDR: begin
                     if (hdr_idx == 2'd2) begin
                        state_nxt = SETUP;
                     end else begin
                        hdr_idx_nxt = hdr_idx + 2'd1;
                        state_nxt   = HDR;
                     end
                  end
                  PH_PAR:  state_nxt = NEXT;
                  default: state_nxt = FIN;
               endcase
            end
         end
         NEXT: begin
            seq_step = 1'b1;
            if (seq_last_all) begin
`ifdef SYSEX_FRAME_EN
               state_nxt = TRL;
`else
               state_nxt = FIN;
`endif
            end else begin
               state_nxt = SETUP;
            end
         end
         TRL: begin
            tx_byte_nxt = EOX;
            phase_nxt   = PH_TRL;
            state_nxt   = SEND;
         end
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Address and select stay on the bus while a captured parameter waits in SEND
   assign bus_act = (state == SETUP) || (state == STROBE) || (state == CAPTURE) ||
                    ((state == SEND) && (phase == PH_PAR));

   assign adr     = bus_act ? seq_adr : 7'd0;
   assign osc_sel = bus_act && (seq_bank == BANK_OSC);
   assign com_sel = bus_act && (seq_bank == BANK_COM);
   assign m1_sel  = bus_act && (seq_bank == BANK_M1);
   assign m2_sel  = bus_act && (seq_bank == BANK_M2);
   assign read    = (state == STROBE) || (state == CAPTURE);

   assign tx_valid = (state == SEND);
   assign tx_data  = tx_valid ? tx_byte : 8'h00;

   assign busy                  = (state != IDLE) && (state != FIN);
   assign sysex_data_patch_send = (state != IDLE) && (state != FIN);
   assign done                  = (state == FIN);

endmodule

// File: tb/tb_sysex_patch_dump.sv
// tb/tb_sysex_patch_dump.sv - directed bench for sysex_patch_dump (raw, or framed with SYSEX_FRAME_EN)
module tb_sysex_patch_dump;

`ifdef SYSEX_FRAME_EN
   localparam int HDR_N = 3;
   localparam int TOTAL = 187;
`else
   localparam int HDR_N = 0;
   localparam int TOTAL = 183;
`endif

   logic       sCLK_XVXENVS = 1'b0;
   logic       reset_reg_N  = 1'b1;
   logic       start        = 1'b0;
   logic       tx_ready     = 1'b1;
   logic       busy, done, read, sysex_data_patch_send, tx_valid;
   logic       osc_sel, com_sel, m1_sel, m2_sel;
   logic [6:0] adr;
   logic [7:0] data, tx_data;

   int         n_tests = 0;
   int         n_fail  = 0;
   int         done_cnt = 0;
   int         sel_err  = 0;
   bit         ovr      = 1'b0;
   logic [7:0] resp_q   = 8'h00;
   logic [7:0] rx_q[$];
   logic [7:0] exp_q[$];
   int         exp_adr[$];
   int         ofs[10] = '{2, 3, 4, 7, 10, 11, 12, 13, 14, 15};

   always #5 sCLK_XVXENVS = ~sCLK_XVXENVS;

   sysex_patch_dump #(.V_OSC(4), .MFR_ID(8'h7D), .DEV_ID(8'h00)) dut (
      .sCLK_XVXENVS          (sCLK_XVXENVS),
      .reset_reg_N           (reset_reg_N),
      .start                 (start),
      .busy                  (busy),
      .done                  (done),
      .adr                   (adr),
      .osc_sel               (osc_sel),
      .com_sel               (com_sel),
      .m1_sel                (m1_sel),
      .m2_sel                (m2_sel),
      .read                  (read),
      .sysex_data_patch_send (sysex_data_patch_send),
      .data                  (data),
      .tx_data               (tx_data),
      .tx_valid              (tx_valid),
      .tx_ready              (tx_ready)
   );

   // Responder reset contents: osc 3E+adr, com 10+adr, m1 adr, m2 7F-adr
   function automatic logic [7:0] resp_val(input int bnk, input int a, input bit o);
      int v;
      case (bnk)
         0:       v = 32'h3E + a;
         1:       v = 32'h10 + a;
         2:       v = (o && a == 33) ? 32'hC5 : a;
         default: v = 32'h7F - a;
      endcase
      return v[7:0];
   endfunction

   always @(posedge read) begin
      if (osc_sel)     resp_q <= resp_val(0, int'(adr), ovr);
      else if (com_sel) resp_q <= resp_val(1, int'(adr), ovr);
      else if (m1_sel)  resp_q <= resp_val(2, int'(adr), ovr);
      else if (m2_sel)  resp_q <= resp_val(3, int'(adr), ovr);
      else              resp_q <= 8'hEE;
   end

   assign data = sysex_data_patch_send ? resp_q : 8'h00;

   always @(negedge sCLK_XVXENVS) begin
      if (tx_valid && tx_ready) rx_q.push_back(tx_data);
      if (done) done_cnt++;
      if ($countones({osc_sel, com_sel, m1_sel, m2_sel}) > 1) sel_err++;
   end

   task automatic push_exp(input logic [7:0] v, input int a);
      exp_q.push_back({1'b0, v[6:0]});
      exp_adr.push_back(a);
   endtask

   task automatic build_exp(input bit o);
      exp_q.delete();
      exp_adr.delete();
`ifdef SYSEX_FRAME_EN
      exp_q.push_back(8'hF0); exp_adr.push_back(-1);
      exp_q.push_back(8'h7D); exp_adr.push_back(-1);
      exp_q.push_back(8'h00); exp_adr.push_back(-1);
`endif
      for (int n = 0; n < 4; n++)
         for (int k = 0; k < 10; k++) push_exp(resp_val(0, n * 16 + ofs[k], o), n * 16 + ofs[k]);
      for (int a = 1; a <= 15; a++) push_exp(resp_val(1, a, o), a);
      for (int a = 0; a < 64; a++) push_exp(resp_val(2, a, o), a);
      for (int a = 0; a < 64; a++) push_exp(resp_val(3, a, o), a);
`ifdef SYSEX_FRAME_EN
      exp_q.push_back(8'hF7); exp_adr.push_back(-1);
`endif
   endtask

   task automatic pulse_start();
      @(posedge sCLK_XVXENVS); #1 start = 1'b1;
      @(posedge sCLK_XVXENVS); #1 start = 1'b0;
   endtask

   task automatic wait_done(input int d0, input string nm);
      for (int k = 0; k < 3000; k++) begin
         @(negedge sCLK_XVXENVS);
         if (done_cnt > d0) return;
      end
      n_tests++; n_fail++;
      $display("FAIL %s: no done pulse within 3000 cycles", nm);
   endtask

   task automatic test_reset();
      #2 reset_reg_N = 1'b0;
      repeat (3) @(negedge sCLK_XVXENVS);
      n_tests++;
      if ({adr, osc_sel, com_sel, m1_sel, m2_sel, read, sysex_data_patch_send,
           tx_valid, tx_data, busy, done} !== 30'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: adr=%h sel=%b read=%b send=%b txv=%b txd=%h busy=%b done=%b, want all 0",
                  adr, {osc_sel, com_sel, m1_sel, m2_sel}, read, sysex_data_patch_send,
                  tx_valid, tx_data, busy, done);
      end
      @(posedge sCLK_XVXENVS); #1 reset_reg_N = 1'b1;
      repeat (2) @(negedge sCLK_XVXENVS);
      n_tests++;
      if ({busy, tx_valid, read, sysex_data_patch_send} !== 4'b0000) begin
         n_fail++;
         $display("FAIL idle_after_reset: busy/txv/read/send=%b want 0000",
                  {busy, tx_valid, read, sysex_data_patch_send});
      end
   endtask

   task automatic check_stream(input string nm);
      int mism;
      mism = 0;
      for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
         if (rx_q[i] !== exp_q[i]) mism++;
      n_tests++;
      if (mism != 0 || rx_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL %s: %0d byte mismatches, got %0d bytes want %0d", nm, mism, rx_q.size(), exp_q.size());
      end
   endtask

   task automatic test_full_dump();
      int d0;
      build_exp(1'b0);
      rx_q.delete();
      sel_err = 0;
      d0 = done_cnt;
      pulse_start();
      @(negedge sCLK_XVXENVS);
      n_tests++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_start: got %b want 1", busy); end
      wait_done(d0, "full_dump");
      repeat (5) @(negedge sCLK_XVXENVS);
      n_tests++;
      if (rx_q.size() != TOTAL) begin n_fail++; $display("FAIL byte_count: got %0d want %0d", rx_q.size(), TOTAL); end
      if (rx_q.size() >= 4) begin
`ifdef SYSEX_FRAME_EN
         n_tests++;
         if ({rx_q[0], rx_q[1], rx_q[2], rx_q[3]} !== 32'hF07D0040) begin
            n_fail++;
            $display("FAIL first_bytes: got %h %h %h %h want f0 7d 00 40", rx_q[0], rx_q[1], rx_q[2], rx_q[3]);
         end
         n_tests++;
         if (rx_q[rx_q.size() - 1] !== 8'hF7) begin n_fail++; $display("FAIL last_byte: got %h want f7", rx_q[rx_q.size() - 1]); end
`else
         n_tests++;
         if ({rx_q[0], rx_q[1]} !== 16'h4041) begin
            n_fail++;
            $display("FAIL first_bytes: got %h %h want 40 41", rx_q[0], rx_q[1]);
         end
         n_tests++;
         if (rx_q[rx_q.size() - 1] !== 8'h40) begin n_fail++; $display("FAIL last_byte: got %h want 40", rx_q[rx_q.size() - 1]); end
`endif
      end
      check_stream("full_stream");
      n_tests++;
      if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL done_pulses: got %0d want 1", done_cnt - d0); end
      n_tests++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_after_done: got %b want 0", busy); end
      n_tests++;
      if (sel_err != 0) begin n_fail++; $display("FAIL select_onehot: %0d cycles with >1 select", sel_err); end
   endtask

   task automatic test_stall();
      int d0, bad_d, bad_a;
      bit hit;
      build_exp(1'b0);
      rx_q.delete();
      d0 = done_cnt;
      pulse_start();
      hit = 1'b0;
      for (int k = 0; k < 200 && !hit; k++) begin
         @(posedge sCLK_XVXENVS); #1;
         if (rx_q.size() == 4) begin tx_ready = 1'b0; hit = 1'b1; end
      end
      hit = 1'b0;
      for (int k = 0; k < 20 && !hit; k++) begin
         @(negedge sCLK_XVXENVS);
         if (tx_valid) hit = 1'b1;
      end
      n_tests++;
      if (!hit) begin n_fail++; $display("FAIL stall_reach: tx_valid not seen for byte 5"); end
      bad_d = 0; bad_a = 0;
      for (int k = 0; k < 20; k++) begin
         if (tx_data !== exp_q[4] || tx_valid !== 1'b1) bad_d++;
         if (int'(adr) != exp_adr[4]) bad_a++;
         @(negedge sCLK_XVXENVS);
      end
      n_tests++;
      if (bad_d != 0) begin n_fail++; $display("FAIL stall_tx_data: %0d cycles off, last %h want %h", bad_d, tx_data, exp_q[4]); end
      n_tests++;
      if (bad_a != 0) begin n_fail++; $display("FAIL stall_adr: %0d cycles off, last %h want %h", bad_a, adr, exp_adr[4]); end
      @(posedge sCLK_XVXENVS); #1 tx_ready = 1'b1;
      wait_done(d0, "stall");
      repeat (3) @(negedge sCLK_XVXENVS);
      check_stream("stall_stream");
   endtask

   task automatic test_override();
      int d0;
      ovr = 1'b1;
      build_exp(1'b1);
      rx_q.delete();
      d0 = done_cnt;
      pulse_start();
      wait_done(d0, "override");
      repeat (3) @(negedge sCLK_XVXENVS);
      n_tests++;
      if (rx_q.size() <= HDR_N + 88 || rx_q[HDR_N + 88] !== 8'h45) begin
         n_fail++;
         $display("FAIL m1_21_masked: got %h want 45", (rx_q.size() > HDR_N + 88) ? rx_q[HDR_N + 88] : 8'hxx);
      end
      check_stream("override_stream");
      ovr = 1'b0;
   endtask

   task automatic test_reset_mid();
      int d0;
      bit hit;
      build_exp(1'b0);
      rx_q.delete();
      pulse_start();
      hit = 1'b0;
      for (int k = 0; k < 600 && !hit; k++) begin
         @(posedge sCLK_XVXENVS); #1;
         if (rx_q.size() >= 50) hit = 1'b1;
      end
      n_tests++;
      if (!hit) begin n_fail++; $display("FAIL reset_mid_reach: only %0d bytes", rx_q.size()); end
      @(negedge sCLK_XVXENVS); #2 reset_reg_N = 1'b0;
      #1;
      n_tests++;
      if ({adr, osc_sel, com_sel, m1_sel, m2_sel, read, sysex_data_patch_send,
           tx_valid, tx_data, busy, done} !== 30'd0) begin
         n_fail++;
         $display("FAIL reset_mid_outputs: adr=%h sel=%b read=%b send=%b txv=%b txd=%h busy=%b, want all 0",
                  adr, {osc_sel, com_sel, m1_sel, m2_sel}, read, sysex_data_patch_send, tx_valid, tx_data, busy);
      end
      repeat (3) @(posedge sCLK_XVXENVS);
      #1 reset_reg_N = 1'b1;
      repeat (2) @(negedge sCLK_XVXENVS);
      rx_q.delete();
      d0 = done_cnt;
      pulse_start();
      wait_done(d0, "reset_restart");
      repeat (3) @(negedge sCLK_XVXENVS);
      n_tests++;
`ifdef SYSEX_FRAME_EN
      if (rx_q.size() == 0 || rx_q[0] !== 8'hF0) begin n_fail++; $display("FAIL restart_first: got %h want f0", (rx_q.size() > 0) ? rx_q[0] : 8'hxx); end
`else
      if (rx_q.size() == 0 || rx_q[0] !== 8'h40) begin n_fail++; $display("FAIL restart_first: got %h want 40", (rx_q.size() > 0) ? rx_q[0] : 8'hxx); end
`endif
      check_stream("restart_stream");
   endtask

   task automatic test_restart_ignored();
      int d0;
      build_exp(1'b0);
      rx_q.delete();
      d0 = done_cnt;
      pulse_start();
      repeat (30) @(posedge sCLK_XVXENVS);
      pulse_start();
      repeat (200) @(posedge sCLK_XVXENVS);
      pulse_start();
      wait_done(d0, "restart_ignored");
      repeat (20) @(negedge sCLK_XVXENVS);
      n_tests++;
      if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL restart_done: got %0d pulses want 1", done_cnt - d0); end
      check_stream("restart_ignored_stream");
   endtask

   initial begin
      test_reset();
      test_full_dump();
      test_stall();
      test_override();
      test_reset_mid();
      test_restart_ignored();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
